// File: rtl/du_controller.sv
// du_controller: debug-unit command controller.
// Decodes single-byte host commands from the UART receiver. Loads programs into
// instruction memory, gates CPU execution in run and step modes, and starts the
// register-file/PC dump transmitter.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for a command byte
// LOAD_CNT  | next rx byte is the word count (0 means 256 words)
// LOAD_WORD | assembling 4 little-endian bytes per instruction word
// RUN       | CPU enabled until i_cpu_halt is sampled high
// STEP      | CPU enabled for this single cycle
// DUMP      | dump started; waiting for i_dump_done
module du_controller #(
    parameter int NB_UART_DATA = 8,
    parameter int NB_INSTR     = 32,
    parameter int NB_IMEM_ADDR = 10
) (
    input  logic                    clk,
    input  logic                    i_rst,
    input  logic                    i_rx_done,
    input  logic [NB_UART_DATA-1:0] i_rx_data,
    input  logic                    i_cpu_halt,
    input  logic                    i_dump_done,
    output logic                    o_dump_start,
    output logic                    o_cpu_en,
    output logic                    o_cpu_rst,
    output logic                    o_imem_we,
    output logic [NB_IMEM_ADDR-1:0] o_imem_waddr,
    output logic [NB_INSTR-1:0]     o_imem_wdata,
    output logic                    o_load_done,
    output logic                    o_busy
);

    localparam logic [NB_UART_DATA-1:0] CMD_LOAD  = NB_UART_DATA'(8'h4C);
    localparam logic [NB_UART_DATA-1:0] CMD_RUN   = NB_UART_DATA'(8'h43);
    localparam logic [NB_UART_DATA-1:0] CMD_STEP  = NB_UART_DATA'(8'h53);
    localparam logic [NB_UART_DATA-1:0] CMD_DUMP  = NB_UART_DATA'(8'h44);
    localparam logic [NB_UART_DATA-1:0] CMD_RESET = NB_UART_DATA'(8'h52);

    // One extra bit so a count byte of 0 can represent 2^NB_UART_DATA words.
    localparam int NB_CNT = NB_UART_DATA + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CNT,
        LOAD_WORD,
        RUN,
        STEP,
        DUMP
    } state_t;

    state_t                  state;
    logic [1:0]              byte_cnt;
    logic [NB_INSTR-1:0]     word_buf;
    logic [NB_CNT-1:0]       words_left;
    logic [NB_IMEM_ADDR-1:0] addr;

    // CPU enable and busy are decoded from registered state only.
    assign o_cpu_en = (state == RUN) || (state == STEP);
    assign o_busy   = (state != IDLE);

    // Command decode, program load and run/step/dump sequencing.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            byte_cnt     <= '0;
            word_buf     <= '0;
            words_left   <= '0;
            addr         <= '0;
            o_dump_start <= 1'b0;
            o_cpu_rst    <= 1'b0;
            o_imem_we    <= 1'b0;
            o_imem_waddr <= '0;
            o_imem_wdata <= '0;
            o_load_done  <= 1'b0;
        end else begin
            o_dump_start <= 1'b0;
            o_cpu_rst    <= 1'b0;
            o_imem_we    <= 1'b0;
            o_load_done  <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_rx_done) begin
                        case (i_rx_data)
                            CMD_LOAD: begin
                                o_cpu_rst    <= 1'b1;
                                addr         <= '0;
                                o_imem_waddr <= '0;
                                byte_cnt     <= '0;
                                state        <= LOAD_CNT;
                            end
                            CMD_RUN:   state <= RUN;
                            CMD_STEP:  state <= STEP;
                            CMD_DUMP: begin
                                o_dump_start <= 1'b1;
                                state        <= DUMP;
                            end
                            CMD_RESET: o_cpu_rst <= 1'b1;
                            default:   state <= IDLE;
                        endcase
                    end
                end

                LOAD_CNT: begin
                    if (i_rx_done) begin
                        words_left <= {(i_rx_data == '0), i_rx_data};
                        byte_cnt   <= '0;
                        state      <= LOAD_WORD;
                    end
                end

                LOAD_WORD: begin
                    if (i_rx_done) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            o_imem_we    <= 1'b1;
                            o_imem_wdata <= {i_rx_data, word_buf[NB_INSTR-NB_UART_DATA-1:0]};
                            o_imem_waddr <= addr;
                            addr         <= addr + 1'b1;
                            words_left   <= words_left - 1'b1;
                            if (words_left == NB_CNT'(1)) begin
                                o_load_done <= 1'b1;
                                state       <= IDLE;
                            end
                        end else begin
                            word_buf[byte_cnt*NB_UART_DATA +: NB_UART_DATA] <= i_rx_data;
                        end
                    end
                end

                RUN: begin
                    if (i_cpu_halt) begin
                        o_dump_start <= 1'b1;
                        state        <= DUMP;
                    end
                end

                STEP: begin
                    o_dump_start <= 1'b1;
                    state        <= DUMP;
                end

                DUMP: begin
                    // A done level seen during the start cycle is left over from
                    // the previous dump, so it is not treated as completion.
                    if (i_dump_done && !o_dump_start) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
